// File: rtl/task7_sequencer_pkg.sv
// Shared state encoding and float constants for the y = 0.5*x + x^2*cos((x-128)/128) sequencer.
package task7_sequencer_pkg;

    typedef enum logic [3:0] {
        StIdle, StSub, StScale, StCStart, StCWait, StSq, StCos, StHalf, StAdd, StDone
    } seq_state_e;

    localparam logic [31:0] Fp128    = 32'h4300_0000;
    localparam logic [31:0] FpInv128 = 32'h3C00_0000;
    localparam logic [31:0] FpHalf   = 32'h3F00_0000;
    localparam logic [31:0] FpQnan   = 32'h7FC0_0000;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/task7_sequencer.sv
// Sequences one shared FP multiplier, one FP add/sub and an external CORDIC to evaluate
// y = 0.5*x + x^2*cos((x-128)/128); every output is registered.
module task7_sequencer
    import task7_sequencer_pkg::*;
#(
    parameter int unsigned MUL_LAT        = 2,
    parameter int unsigned ADD_LAT        = 3,
    parameter int unsigned CORDIC_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        err,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [31:0] mul_result,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    output logic        add_sub,
    input  logic [31:0] add_result,
    output logic        cordic_start,
    output logic [31:0] cordic_angle,
    input  logic [31:0] cordic_cos,
    input  logic        cordic_done
);

    localparam int unsigned CntMax = max3(MUL_LAT, ADD_LAT, CORDIC_TIMEOUT);
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam logic [CntW-1:0] MulLast = CntW'(MUL_LAT - 1);
    localparam logic [CntW-1:0] AddLast = CntW'(ADD_LAT - 1);
    localparam logic [CntW-1:0] ToLast  = CntW'(CORDIC_TIMEOUT - 1);

    seq_state_e      r_state;
    logic [CntW-1:0] r_cnt;
    logic [31:0]     r_x, r_cos, r_p;
    logic            r_in_ready, r_out_valid, r_err, r_add_sub, r_cordic_start;
    logic [31:0]     r_result, r_mul_a, r_mul_b, r_add_a, r_add_b, r_cordic_angle;

    // The operand registers double as holding registers for t, angle, sq and h:
    // each intermediate is consumed only by the state that directly follows its producer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= StIdle;
            r_cnt          <= '0;
            r_x            <= '0;
            r_cos          <= '0;
            r_p            <= '0;
            r_in_ready     <= 1'b1;
            r_out_valid    <= 1'b0;
            r_err          <= 1'b0;
            r_result       <= '0;
            r_mul_a        <= '0;
            r_mul_b        <= '0;
            r_add_a        <= '0;
            r_add_b        <= '0;
            r_add_sub      <= 1'b0;
            r_cordic_start <= 1'b0;
            r_cordic_angle <= '0;
        end else begin
            r_cordic_start <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        r_x        <= data;
                        r_add_a    <= data;
                        r_add_b    <= Fp128;
                        r_add_sub  <= 1'b1;
                        r_in_ready <= 1'b0;
                        r_cnt      <= '0;
                        r_state    <= StSub;
                    end
                end
                StSub: begin
                    if (r_cnt == AddLast) begin
                        r_add_a   <= '0;
                        r_add_b   <= '0;
                        r_add_sub <= 1'b0;
                        r_mul_a   <= add_result;
                        r_mul_b   <= FpInv128;
                        r_cnt     <= '0;
                        r_state   <= StScale;
                    end else begin
                        r_cnt <= r_cnt + CntW'(1);
                    end
                end
                StScale: begin
                    if (r_cnt == MulLast) begin
                        r_mul_a        <= '0;
                        r_mul_b        <= '0;
                        r_cordic_angle <= mul_result;
                        r_cordic_start <= 1'b1;
                        r_cnt          <= '0;
                        r_state        <= StCStart;
                    end else begin
                        r_cnt <= r_cnt + CntW'(1);
                    end
                end
                StCStart: begin
                    r_cnt   <= '0;
                    r_state <= StCWait;
                end
                StCWait: begin
                    if (cordic_done) begin
                        r_cos          <= cordic_cos;
                        r_cordic_angle <= '0;
                        r_mul_a        <= r_x;
                        r_mul_b        <= r_x;
                        r_cnt          <= '0;
                        r_state        <= StSq;
                    end else if (r_cnt == ToLast) begin
                        r_cordic_angle <= '0;
                        r_err          <= 1'b1;
                        r_result       <= FpQnan;
                        r_out_valid    <= 1'b1;
                        r_cnt          <= '0;
                        r_state        <= StDone;
                    end else begin
                        r_cnt <= r_cnt + CntW'(1);
                    end
                end
                StSq: begin
                    if (r_cnt == MulLast) begin
                        r_mul_a <= mul_result;
                        r_mul_b <= r_cos;
                        r_cnt   <= '0;
                        r_state <= StCos;
                    end else begin
                        r_cnt <= r_cnt + CntW'(1);
                    end
                end
                StCos: begin
                    if (r_cnt == MulLast) begin
                        r_p     <= mul_result;
                        r_mul_a <= FpHalf;
                        r_mul_b <= r_x;
                        r_cnt   <= '0;
                        r_state <= StHalf;
                    end else begin
                        r_cnt <= r_cnt + CntW'(1);
                    end
                end
                StHalf: begin
                    if (r_cnt == MulLast) begin
                        r_mul_a   <= '0;
                        r_mul_b   <= '0;
                        r_add_a   <= mul_result;
                        r_add_b   <= r_p;
                        r_add_sub <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= StAdd;
                    end else begin
                        r_cnt <= r_cnt + CntW'(1);
                    end
                end
                StAdd: begin
                    if (r_cnt == AddLast) begin
                        r_add_a     <= '0;
                        r_add_b     <= '0;
                        r_result    <= add_result;
                        r_err       <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= StDone;
                    end else begin
                        r_cnt <= r_cnt + CntW'(1);
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= StIdle;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign result       = r_result;
    assign err          = r_err;
    assign mul_a        = r_mul_a;
    assign mul_b        = r_mul_b;
    assign add_a        = r_add_a;
    assign add_b        = r_add_b;
    assign add_sub      = r_add_sub;
    assign cordic_start = r_cordic_start;
    assign cordic_angle = r_cordic_angle;

endmodule

// File: tb/tb_task7_sequencer.sv
// Self-checking bench for task7_sequencer: float unit models, table vectors, random x
// against a formula-level reference, and hand-written timeout/backpressure/reset sequences.
module tb_task7_sequencer;

    localparam int MUL_LAT   = 2;
    localparam int ADD_LAT   = 3;
    localparam int TIMEOUT   = 64;
    localparam int COS_DELAY = 10;
    localparam int NOM_LAT   = 2 * ADD_LAT + 4 * MUL_LAT + 1 + COS_DELAY;
    localparam int TO_LAT    = ADD_LAT + MUL_LAT + 1 + TIMEOUT;

    logic        clk = 1'b0;
    logic        reset, in_valid, out_ready;
    logic [31:0] data;
    logic        in_ready, out_valid, err, add_sub, cordic_start, cordic_done;
    logic [31:0] result, mul_a, mul_b, mul_result, add_a, add_b, add_result;
    logic [31:0] cordic_angle, cordic_cos;

    int n_checks = 0;
    int n_fail   = 0;

    task7_sequencer #(
        .MUL_LAT        (MUL_LAT),
        .ADD_LAT        (ADD_LAT),
        .CORDIC_TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .data         (data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .err          (err),
        .mul_a        (mul_a),
        .mul_b        (mul_b),
        .mul_result   (mul_result),
        .add_a        (add_a),
        .add_b        (add_b),
        .add_sub      (add_sub),
        .add_result   (add_result),
        .cordic_start (cordic_start),
        .cordic_angle (cordic_angle),
        .cordic_cos   (cordic_cos),
        .cordic_done  (cordic_done)
    );

    always #5 clk = ~clk;

    // Float helpers: normals and zero only, round-to-nearest-even from double.
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:0] == 31'd0) d = {f[31], 63'd0};
        else d = {f[31], 11'(int'(f[30:23]) + 896), f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [31:0] b;
        int e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        e = int'(d[62:52]) - 896;
        b = {d[63], e[7:0], d[51:29]};
        if (d[28] && ((d[27:0] != 28'd0) || d[29])) b = b + 32'd1;
        return b;
    endfunction

    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) * f2r(b));
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b,
                                         input logic sub);
        return r2f(sub ? f2r(a) - f2r(b) : f2r(a) + f2r(b));
    endfunction

    function automatic logic [31:0] fcos(input logic [31:0] a);
        return r2f($cos(f2r(a)));
    endfunction

    // Reference: y = 0.5*x + x^2 * cos((x-128)/128), using the same float unit models.
    function automatic logic [31:0] ref_y(input logic [31:0] x);
        logic [31:0] ang;
        ang = fmul(fadd(x, 32'h4300_0000, 1'b1), 32'h3C00_0000);
        return fadd(fmul(32'h3F00_0000, x), fmul(fmul(x, x), fcos(ang)), 1'b0);
    endfunction

    // Fixed-latency unit models.
    logic [31:0] mul_pipe [MUL_LAT-1];
    logic [31:0] add_pipe [ADD_LAT-1];
    always @(posedge clk) begin
        mul_pipe[0] <= fmul(mul_a, mul_b);
        for (int i = 1; i < MUL_LAT - 1; i++) mul_pipe[i] <= mul_pipe[i-1];
        add_pipe[0] <= fadd(add_a, add_b, add_sub);
        for (int i = 1; i < ADD_LAT - 1; i++) add_pipe[i] <= add_pipe[i-1];
    end
    assign mul_result = mul_pipe[MUL_LAT-2];
    assign add_result = add_pipe[ADD_LAT-2];

    logic        cordic_en = 1'b1;
    logic        stray     = 1'b0;
    logic        cdone_q   = 1'b0;
    logic [31:0] ccos_q    = 32'd0;
    int          ccnt      = 0;
    always @(posedge clk) begin
        if (cordic_start && cordic_en) begin
            ccnt    <= COS_DELAY;
            ccos_q  <= fcos(cordic_angle);
            cdone_q <= 1'b0;
        end else begin
            if (ccnt > 0) ccnt <= ccnt - 1;
            cdone_q <= (ccnt == 2);
        end
    end
    assign cordic_done = cdone_q | stray;
    assign cordic_cos  = ccos_q;

    // Bus hygiene: one unit in use at a time, idle buses quiet, single-cycle start pulse.
    logic viol = 1'b0;
    logic prev_start = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            if (((mul_a | mul_b) != 32'd0) && (((add_a | add_b) != 32'd0) || add_sub)) viol <= 1'b1;
            if (in_ready && ((mul_a | mul_b | add_a | add_b | cordic_angle) != 32'd0)) viol <= 1'b1;
            if (prev_start && cordic_start) viol <= 1'b1;
        end
        prev_start <= cordic_start;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Waits for out_valid; lat counts posedges from the current point.
    task automatic wait_out(output int lat);
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL out_valid_timeout: got no out_valid, expected one within 200 cycles");
        end
    endtask

    task automatic run_x(input logic [31:0] x, output logic [31:0] res, output logic e,
                         output int lat);
        @(negedge clk);
        in_valid = 1'b1;
        data     = x;
        for (int k = 0; k < 100 && !in_ready; k++) @(negedge clk);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_out(lat);
        res = result;
        e   = err;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic        e;
        int          lat;
    } vec_t;

    vec_t        vecs [4];
    logic [31:0] res, saved, x;
    logic        e, bad;
    int          lat;

    initial begin
        vecs[0] = '{x: 32'h4300_0000, y: 32'h4680_8000, e: 1'b0, lat: NOM_LAT};
        vecs[1] = '{x: 32'h0000_0000, y: 32'h0000_0000, e: 1'b0, lat: NOM_LAT};
        vecs[2] = '{x: 32'h8000_0000, y: 32'h0000_0000, e: 1'b0, lat: NOM_LAT};
        vecs[3] = '{x: 32'h4380_0000, y: ref_y(32'h4380_0000), e: 1'b0, lat: NOM_LAT};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; data = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_cordic_start", {31'd0, cordic_start}, 32'd0);
        check("rst_buses", mul_a | mul_b | add_a | add_b | cordic_angle | {31'd0, add_sub}, 32'd0);

        for (int i = 0; i < 4; i++) begin
            run_x(vecs[i].x, res, e, lat);
            check("vec_result", res, vecs[i].y);
            check("vec_err", {31'd0, e}, {31'd0, vecs[i].e});
            check("vec_latency", 32'(lat), 32'(vecs[i].lat));
        end

        for (int i = 0; i < 16; i++) begin
            x = {1'($urandom), 8'($urandom_range(118, 134)), 23'($urandom)};
            run_x(x, res, e, lat);
            check("rand_result", res, ref_y(x));
            check("rand_err", {31'd0, e}, 32'd0);
            check("rand_latency", 32'(lat), 32'(NOM_LAT));
        end

        // CORDIC silent: timeout path, then a stray done while idle.
        cordic_en = 1'b0;
        run_x(32'h4300_0000, res, e, lat);
        check("timeout_result", res, 32'h7FC0_0000);
        check("timeout_err", {31'd0, e}, 32'd1);
        check("timeout_latency", 32'(lat), 32'(TO_LAT));
        cordic_en = 1'b1;
        @(negedge clk); stray = 1'b1;
        @(negedge clk); stray = 1'b0;
        @(posedge clk); #1;
        check("stray_in_ready", {31'd0, in_ready}, 32'd1);
        check("stray_out_valid", {31'd0, out_valid}, 32'd0);
        run_x(32'h4300_0000, res, e, lat);
        check("post_stray_result", res, 32'h4680_8000);
        check("post_stray_err", {31'd0, e}, 32'd0);

        // Backpressure: result held, second input blocked until handshake.
        @(negedge clk); in_valid = 1'b1; data = 32'h4300_0000;
        @(posedge clk); #1;
        data = 32'h0000_0000;
        wait_out(lat);
        saved = result;
        check("bp_result", saved, 32'h4680_8000);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("bp_hold_result", result, saved);
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_after_hs_valid", {31'd0, out_valid}, 32'd0);
        check("bp_after_hs_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_second_accepted", {31'd0, in_ready}, 32'd0);
        wait_out(lat);
        check("bp_second_result", result, 32'h0000_0000);
        check("bp_second_latency", 32'(lat), 32'(NOM_LAT));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset during C_WAIT, late CORDIC done must not leak out.
        @(negedge clk); in_valid = 1'b1; data = 32'h4300_0000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_result", result, 32'd0);
        bad = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (out_valid || !in_ready || err) bad = 1'b1;
        end
        check("midrst_no_spurious", {31'd0, bad}, 32'd0);
        run_x(32'h4300_0000, res, e, lat);
        check("midrst_next_result", res, 32'h4680_8000);
        check("midrst_next_err", {31'd0, e}, 32'd0);
        check("midrst_next_latency", 32'(lat), 32'(NOM_LAT));

        check("bus_hygiene", {31'd0, viol}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at 1000000, expected to finish earlier");
        $fatal(1, "watchdog");
    end

endmodule
